// File: rtl/fetch_stage_if.sv
// IF-stage bundle: redirect/stall control and imem handshake in, IF/ID register out.
// master = the fetch stage, slave = imem, hazard unit and ID side.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [15:0] pcRedirect;
  logic [15:0] imemInstr;
  logic        imemValid;
  logic [15:0] imemAddr;
  logic [15:0] ifidInstr;
  logic [15:0] ifidPcInc;
  logic        ifidValid;
  logic        halted;

  modport master (
    input  stall, redirect, pcRedirect, imemInstr, imemValid,
    output imemAddr, ifidInstr, ifidPcInc, ifidValid, halted
  );

  modport slave (
    output stall, redirect, pcRedirect, imemInstr, imemValid,
    input  imemAddr, ifidInstr, ifidPcInc, ifidValid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 16-bit core: PC register, IF/ID pipeline register and halt latch.
// Priority each cycle: redirect > stall > halted > imem not valid > fetch.
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcInc;
    logic        valid;
  } ifid_t;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pcInc: 16'h0000, valid: 1'b0};

  state_t      state, stateNext;
  logic [15:0] pc, pcNext, pcInc;
  ifid_t       ifid, ifidNext;
  logic        isHlt;

  assign pcInc = pc + 16'd2;
  assign isHlt = (bus.imemInstr[15:12] == HLT_OPCODE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
      ifid  <= BUBBLE;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      ifid  <= ifidNext;
    end
  end

  // The word sitting on imemInstr during a redirect is wrong-path and is
  // never latched, so a HLT arriving alongside a redirect cannot halt us.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    ifidNext  = ifid;
    if (bus.redirect) begin
      pcNext    = bus.pcRedirect & 16'hFFFE;
      ifidNext  = BUBBLE;
      stateNext = ST_RUN;
    end else if (bus.stall) begin
      // hold everything, including across a missing imem word
    end else if (state == ST_HALT) begin
      ifidNext = BUBBLE;
    end else if (!bus.imemValid) begin
      ifidNext = BUBBLE;
    end else begin
      ifidNext = '{instr: bus.imemInstr, pcInc: pcInc, valid: 1'b1};
      if (isHlt) stateNext = ST_HALT;
      else       pcNext    = pcInc;
    end
  end

  assign bus.imemAddr  = pc;
  assign bus.ifidInstr = ifid.instr;
  assign bus.ifidPcInc = ifid.pcInc;
  assign bus.ifidValid = ifid.valid;
  assign bus.halted    = (state == ST_HALT);

endmodule
